round_key_store: RTL and testbench
==================================

ROUND_KEY_STORE -- requirements
Module: round_key_store

Interface
REQ-001 Parameter DEPTH, default 15, SHALL set the maximum number of stored 128-bit round keys (15 = AES-256).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  round-key beat present from the key-expansion stream.
REQ-005 in_first_flag  input  1  beat is round key 0; meaningful only with in_valid.
REQ-006 in_last_flag  input  1  beat is final round key; meaningful only with in_valid.
REQ-007 in_rk  input  128  round key data.
REQ-008 in_clear  input  1  synchronous discard of all stored keys.
REQ-009 rd_start  input  1  request playback of stored keys.
REQ-010 rd_dir  input  1  playback order, sampled with rd_start: 0 = index 0 upward (encrypt), 1 = index count-1 downward (decrypt).
REQ-011 rd_ready  input  1  consumer accepts current rd_rk.
REQ-012 rd_valid  output  1  rd_rk holds a valid key.
REQ-013 rd_rk  output  128  key under playback.
REQ-014 rd_first  output  1  rd_rk is first key of this playback.
REQ-015 rd_last  output  1  rd_rk is final key of this playback.
REQ-016 out_ready  output  1  complete key schedule stored (READY or READ state).
REQ-017 out_busy  output  1  schedule capture in progress (FILL state).
REQ-018 out_count  output  4  number of keys in last complete schedule.
REQ-019 out_err  output  1  sticky protocol/overflow error.

Function
REQ-020 The block SHALL implement states EMPTY, FILL, READY, READ.
REQ-021 in_clear SHALL, highest priority, force EMPTY, out_count=0, rd_valid=0, out_err=0 on the next edge, ignoring same-cycle in_valid and rd_start.
REQ-022 in_valid with in_first_flag in any state SHALL write in_rk to entry 0, set write pointer to 1, enter FILL, drop rd_valid, clear out_err (aborts any playback).
REQ-023 in_valid without in_first_flag in FILL SHALL write entry at write pointer and increment it.
REQ-024 A FILL-completing beat with in_last_flag SHALL set out_count = index written + 1 and enter READY; first and last in the same beat SHALL yield out_count=1.
REQ-025 A non-first beat when write pointer equals DEPTH SHALL not write, set out_err, enter EMPTY, out_count=0.
REQ-026 in_valid without in_first_flag in EMPTY, READY or READ SHALL be ignored except setting out_err; stored keys and playback SHALL be unaffected.
REQ-027 rd_start in READY SHALL enter READ and present the first key (index 0, or out_count-1 if rd_dir=1) with rd_valid=1 and rd_first=1 on the next cycle; rd_start in any other state SHALL be ignored.
REQ-028 While rd_valid=1 and rd_ready=0, rd_rk, rd_first, rd_last SHALL hold stable.
REQ-029 Each rd_valid&rd_ready handshake SHALL present the next key in the following cycle (one key per cycle at full throughput).
REQ-030 rd_last SHALL be 1 exactly when rd_rk is index out_count-1 (rd_dir=0) or index 0 (rd_dir=1); out_count=1 SHALL assert rd_first and rd_last together.
REQ-031 The handshake on the rd_last key SHALL clear rd_valid next cycle and return to READY with keys retained for replay.
REQ-032 out_ready SHALL be 1 in READY and READ; out_busy SHALL be 1 only in FILL.
REQ-033 Key storage SHALL not be reset; only control state and outputs are reset.

Reset
REQ-034 rst low SHALL immediately force EMPTY, rd_valid=0, rd_rk=0, rd_first=0, rd_last=0, out_ready=0, out_busy=0, out_count=0, out_err=0, pointers=0, including mid-FILL or mid-READ.
REQ-035 After rst deasserts, the block SHALL accept a first-flagged beat on the first rising edge.

Verification
REQ-036 11-beat stream K0..K10 (first on K0, last on K10), then rd_start rd_dir=0, rd_ready=1 -> out_count=11, rd_rk K0..K10 on consecutive cycles, rd_first with K0, rd_last with K10, then READY.
REQ-037 15-beat schedule, rd_dir=1, rd_ready toggled 1/0 -> K14..K0 in order, each key held stable while rd_ready=0, rd_last with K0.
REQ-038 16 non-last beats after first -> out_err=1, EMPTY, out_count=0; rd_start ignored.
REQ-039 Single beat with first and last, playback -> one key with rd_first=rd_last=1.
REQ-040 New first-flagged beat during READ at key 5 -> rd_valid=0 next cycle, FILL; in_clear with in_valid same cycle -> EMPTY, nothing written.
REQ-041 rst asserted mid-playback -> all outputs zero immediately; replay after new 13-key schedule returns only new keys.

Source files
------------

// File: rtl/round_key_store.sv
// Round-key store: captures an AES key-expansion stream into local RAM and
// plays it back forward (encrypt) or reversed (decrypt) with a valid/ready handshake.
module round_key_store #(
    parameter int DEPTH = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_first_flag,
    input  logic         in_last_flag,
    input  logic [127:0] in_rk,
    input  logic         in_clear,
    input  logic         rd_start,
    input  logic         rd_dir,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [127:0] rd_rk,
    output logic         rd_first,
    output logic         rd_last,
    output logic         out_ready,
    output logic         out_busy,
    output logic [3:0]   out_count,
    output logic         out_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        READY,
        READ
    } state_t;

    state_t state_reg, state_next;

    logic [127:0]  key_mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] rd_step, last_idx, wr_addr;
    logic [3:0]    count_reg, count_next;
    logic          err_reg, err_next;
    logic          dir_reg, dir_next;
    logic          valid_reg, valid_next;
    logic          first_reg, first_next;
    logic          last_reg, last_next;
    logic [127:0]  rk_reg;
    logic          wr_en, rk_load;

    assign last_idx = PW'(count_reg - 4'd1);
    assign rd_step  = dir_reg ? (rd_ptr_reg - PW'(1)) : (rd_ptr_reg + PW'(1));

    always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        err_next    = err_reg;
        dir_next    = dir_reg;
        valid_next  = valid_reg;
        first_next  = first_reg;
        last_next   = last_reg;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr_reg;
        rk_load     = 1'b0;

        if (in_clear) begin
            state_next  = EMPTY;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = 4'd0;
            err_next    = 1'b0;
            valid_next  = 1'b0;
            first_next  = 1'b0;
            last_next   = 1'b0;
        end else if (in_valid && in_first_flag) begin
            // A new schedule always restarts capture, even mid-playback.
            wr_en       = 1'b1;
            wr_addr     = '0;
            wr_ptr_next = PW'(1);
            err_next    = 1'b0;
            valid_next  = 1'b0;
            first_next  = 1'b0;
            last_next   = 1'b0;
            if (in_last_flag) begin
                count_next = 4'd1;
                state_next = READY;
            end else begin
                count_next = 4'd0;
                state_next = FILL;
            end
        end else begin
            if (in_valid) begin
                if (state_reg == FILL) begin
                    if (wr_ptr_reg == PTR_FULL) begin
                        err_next   = 1'b1;
                        count_next = 4'd0;
                        state_next = EMPTY;
                    end else begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr_reg + PW'(1);
                        if (in_last_flag) begin
                            count_next = 4'(wr_ptr_reg) + 4'd1;
                            state_next = READY;
                        end
                    end
                end else begin
                    err_next = 1'b1;
                end
            end

            if (state_reg == READY && rd_start) begin
                state_next  = READ;
                dir_next    = rd_dir;
                rd_ptr_next = rd_dir ? last_idx : '0;
                rk_load     = 1'b1;
                valid_next  = 1'b1;
                first_next  = 1'b1;
                last_next   = (count_reg == 4'd1);
            end else if (state_reg == READ && valid_reg && rd_ready) begin
                if (last_reg) begin
                    state_next = READY;
                    valid_next = 1'b0;
                    first_next = 1'b0;
                    last_next  = 1'b0;
                end else begin
                    rd_ptr_next = rd_step;
                    rk_load     = 1'b1;
                    first_next  = 1'b0;
                    last_next   = dir_reg ? (rd_step == '0) : (rd_step == last_idx);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= EMPTY;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= 4'd0;
            err_reg    <= 1'b0;
            dir_reg    <= 1'b0;
            valid_reg  <= 1'b0;
            first_reg  <= 1'b0;
            last_reg   <= 1'b0;
            rk_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
            dir_reg    <= dir_next;
            valid_reg  <= valid_next;
            first_reg  <= first_next;
            last_reg   <= last_next;
            if (rk_load) begin
                rk_reg <= key_mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

    // Key RAM carries no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_mem[wr_addr[AW-1:0]] <= in_rk;
        end
    end

    assign rd_valid  = valid_reg;
    assign rd_rk     = rk_reg;
    assign rd_first  = first_reg;
    assign rd_last   = last_reg;
    assign out_ready = (state_reg == READY) || (state_reg == READ);
    assign out_busy  = (state_reg == FILL);
    assign out_count = count_reg;
    assign out_err   = err_reg;

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: capture, forward/reverse playback,
// backpressure, overflow, clear and reset behaviour.
module tb_round_key_store;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_first_flag, in_last_flag, in_clear;
    logic [127:0] in_rk;
    logic         rd_start, rd_dir, rd_ready;
    logic         rd_valid, rd_first, rd_last;
    logic [127:0] rd_rk;
    logic         out_ready, out_busy, out_err;
    logic [3:0]   out_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string name;
        bit    vld, fst, lst, clr, st, dir, rdy;
        int    kg, ki;
        bit    ev, ef, el;
        int    eg, ei;
        bit    erdy, ebsy;
        int    ecnt;
        bit    eerr;
    } vec_t;

    vec_t tbl[12];

    round_key_store #(.DEPTH(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_first_flag (in_first_flag),
        .in_last_flag  (in_last_flag),
        .in_rk         (in_rk),
        .in_clear      (in_clear),
        .rd_start      (rd_start),
        .rd_dir        (rd_dir),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_rk         (rd_rk),
        .rd_first      (rd_first),
        .rd_last       (rd_last),
        .out_ready     (out_ready),
        .out_busy      (out_busy),
        .out_count     (out_count),
        .out_err       (out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] key(input int g, input int i);
        logic [15:0] gg, ii;
        gg = 16'(g);
        ii = 16'(i);
        return {gg, ii, 32'hDEAD_BEEF, gg ^ 16'h5A5A, ii ^ 16'hA5A5, 32'h1234_5678};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input bit rdy, input bit bsy, input int cnt, input bit err);
        chk({tag, "_ready"}, out_ready, rdy);
        chk({tag, "_busy"}, out_busy, bsy);
        chk({tag, "_count"}, out_count, cnt);
        chk({tag, "_err"}, out_err, err);
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_first_flag = 1'b0;
        in_last_flag  = 1'b0;
        in_clear      = 1'b0;
        in_rk         = '0;
        rd_start      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int g, input int i, input bit first, input bit last);
        in_valid      = 1'b1;
        in_first_flag = first;
        in_last_flag  = last;
        in_rk         = key(g, i);
        tick();
        idle();
    endtask

    task automatic load_schedule(input int g, input int n);
        for (int i = 0; i < n; i++) begin
            send(g, i, i == 0, i == n - 1);
            if (i < n - 1) chk("fill_busy", out_busy, 1'b1);
        end
        $display("loaded schedule gen=%0d keys=%0d count=%0d", g, n, out_count);
    endtask

    task automatic play_forward(input string tag, input int g, input int n);
        rd_start = 1'b1;
        rd_dir   = 1'b0;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, rd_valid, 1'b1);
            chk({tag, "_rk"}, rd_rk, key(g, i));
            chk({tag, "_first"}, rd_first, i == 0);
            chk({tag, "_last"}, rd_last, i == n - 1);
            $display("%s key idx=%0d rk=%h", tag, i, rd_rk);
            tick();
        end
        chk({tag, "_end_valid"}, rd_valid, 1'b0);
        chk({tag, "_end_ready"}, out_ready, 1'b1);
        rd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //           name            vld fst lst clr st dir rdy kg ki  ev ef el eg ei rdy bsy cnt err
        tbl[0]  = '{"start_empty",   0,  0,  0,  0,  1, 0,  1,  0, 0,  0, 0, 0, 0, 0, 0,  0,  0,  0};
        tbl[1]  = '{"stray_empty",   1,  0,  0,  0,  0, 0,  0,  4, 1,  0, 0, 0, 0, 0, 0,  0,  0,  1};
        tbl[2]  = '{"one_key",       1,  1,  1,  0,  0, 0,  0,  5, 0,  0, 0, 0, 0, 0, 1,  0,  1,  0};
        tbl[3]  = '{"stray_ready",   1,  0,  0,  0,  0, 0,  0,  7, 0,  0, 0, 0, 0, 0, 1,  0,  1,  1};
        tbl[4]  = '{"play_one",      0,  0,  0,  0,  1, 1,  0,  0, 0,  1, 1, 1, 5, 0, 1,  0,  1,  1};
        tbl[5]  = '{"hold_one",      0,  0,  0,  0,  0, 0,  0,  0, 0,  1, 1, 1, 5, 0, 1,  0,  1,  1};
        tbl[6]  = '{"ack_one",       0,  0,  0,  0,  0, 0,  1,  0, 0,  0, 0, 0, 0, 0, 1,  0,  1,  1};
        tbl[7]  = '{"replay_one",    0,  0,  0,  0,  1, 0,  1,  0, 0,  1, 1, 1, 5, 0, 1,  0,  1,  1};
        tbl[8]  = '{"ack_replay",    0,  0,  0,  0,  0, 0,  1,  0, 0,  0, 0, 0, 0, 0, 1,  0,  1,  1};
        tbl[9]  = '{"clear_beat",    1,  1,  1,  1,  0, 0,  0,  9, 0,  0, 0, 0, 0, 0, 0,  0,  0,  0};
        tbl[10] = '{"start_cleared", 0,  0,  0,  0,  1, 0,  1,  0, 0,  0, 0, 0, 0, 0, 0,  0,  0,  0};
        tbl[11] = '{"fill_start",    1,  1,  0,  0,  0, 0,  0,  6, 0,  0, 0, 0, 0, 0, 0,  1,  0,  0};

        rst      = 1'b0;
        rd_dir   = 1'b0;
        rd_ready = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_rk", rd_rk, '0);
        chk("rst_first", rd_first, 1'b0);
        chk("rst_last", rd_last, 1'b0);
        chk_status("rst", 0, 0, 0, 0);
        rst = 1'b1;

        // 11-key forward playback at full throughput
        load_schedule(1, 11);
        chk_status("a_loaded", 1, 0, 11, 0);
        play_forward("a", 1, 11);
        chk_status("a_done", 1, 0, 11, 0);

        // 15-key reverse playback with rd_ready toggling
        load_schedule(2, 15);
        chk_status("b_loaded", 1, 0, 15, 0);
        rd_start = 1'b1;
        rd_dir   = 1'b1;
        rd_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        rd_dir   = 1'b0;
        for (int k = 14; k >= 0; k--) begin
            chk("b_valid", rd_valid, 1'b1);
            chk("b_rk", rd_rk, key(2, k));
            chk("b_first", rd_first, k == 14);
            chk("b_last", rd_last, k == 0);
            rd_ready = 1'b0;
            tick();
            chk("b_hold_valid", rd_valid, 1'b1);
            chk("b_hold_rk", rd_rk, key(2, k));
            chk("b_hold_first", rd_first, k == 14);
            chk("b_hold_last", rd_last, k == 0);
            $display("b key idx=%0d rk=%h", k, rd_rk);
            rd_ready = 1'b1;
            tick();
        end
        rd_ready = 1'b0;
        chk("b_end_valid", rd_valid, 1'b0);
        chk_status("b_done", 1, 0, 15, 0);

        // New schedule aborts playback at key 5, then clear beats a same-cycle beat
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("c_at5_rk", rd_rk, key(2, 5));
        chk("c_at5_valid", rd_valid, 1'b1);
        rd_ready      = 1'b0;
        in_valid      = 1'b1;
        in_first_flag = 1'b1;
        in_rk         = key(3, 0);
        tick();
        idle();
        chk("c_abort_valid", rd_valid, 1'b0);
        chk_status("c_abort", 0, 1, 0, 0);
        $display("c abort at key 5 busy=%0b", out_busy);
        in_clear = 1'b1;
        in_valid = 1'b1;
        in_rk    = key(3, 1);
        tick();
        idle();
        chk("c_clear_valid", rd_valid, 1'b0);
        chk_status("c_clear", 0, 0, 0, 0);

        // Table of single-cycle transactions
        for (int r = 0; r < 12; r++) begin
            in_valid      = tbl[r].vld;
            in_first_flag = tbl[r].fst;
            in_last_flag  = tbl[r].lst;
            in_clear      = tbl[r].clr;
            rd_start      = tbl[r].st;
            rd_dir        = tbl[r].dir;
            rd_ready      = tbl[r].rdy;
            in_rk         = key(tbl[r].kg, tbl[r].ki);
            tick();
            idle();
            chk({tbl[r].name, "_valid"}, rd_valid, tbl[r].ev);
            chk_status(tbl[r].name, tbl[r].erdy, tbl[r].ebsy, tbl[r].ecnt, tbl[r].eerr);
            if (tbl[r].ev) begin
                chk({tbl[r].name, "_rk"}, rd_rk, key(tbl[r].eg, tbl[r].ei));
                chk({tbl[r].name, "_first"}, rd_first, tbl[r].ef);
                chk({tbl[r].name, "_last"}, rd_last, tbl[r].el);
            end
            $display("vec %0d %s valid=%0b count=%0d err=%0b", r, tbl[r].name, rd_valid, out_count, out_err);
        end
        rd_ready = 1'b0;
        rd_dir   = 1'b0;

        // Overflow: entry 0 already written by fill_start, 16 more non-last beats
        for (int j = 1; j <= 16; j++) begin
            send(6, j, 1'b0, 1'b0);
            if (j <= 14) chk_status("e_fill", 0, 1, 0, 0);
            else chk_status("e_over", 0, 0, 0, 1);
        end
        $display("overflow err=%0b busy=%0b count=%0d", out_err, out_busy, out_count);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        idle();
        rd_ready = 1'b0;
        chk("e_start_valid", rd_valid, 1'b0);
        chk_status("e_start", 0, 0, 0, 1);

        // Reset mid-playback, then a fresh 13-key schedule right after release
        load_schedule(7, 15);
        chk_status("f_loaded", 1, 0, 15, 0);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("f_at3_rk", rd_rk, key(7, 3));
        rst = 1'b0;
        #1;
        chk("f_rst_valid", rd_valid, 1'b0);
        chk("f_rst_rk", rd_rk, '0);
        chk("f_rst_first", rd_first, 1'b0);
        chk("f_rst_last", rd_last, 1'b0);
        chk_status("f_rst", 0, 0, 0, 0);
        $display("reset mid-playback valid=%0b rk=%h", rd_valid, rd_rk);
        rst      = 1'b1;
        rd_ready = 1'b0;
        load_schedule(8, 13);
        chk_status("f_loaded2", 1, 0, 13, 0);
        play_forward("f", 8, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
